// File: rtl/pulse_gen.sv
// Retriggerable one-shot pulse generator with post-pulse lockout.
// A tick with non-zero len launches a len-cycle pulse; ticks that cannot be honoured raise drop.
module pulse_gen #(
    parameter int CNT_W  = 8,
    parameter int GAP    = 1,
    parameter bit RETRIG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [CNT_W-1:0] len,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [7:0]       GAP_L   = 8'(GAP);
    localparam logic [7:0]       LOCK_ONE = 8'd1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       lock_cnt;
    logic             len_ok;

    assign len_ok = (len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lock_cnt <= '0;
            pulse    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && len_ok) begin
                        cnt   <= len;
                        state <= ACTIVE;
                        pulse <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (RETRIG && tick && len_ok) begin
                        // A reload wins even on the edge that would have ended the pulse.
                        cnt <= len;
                    end else begin
                        if (tick && !RETRIG)
                            drop <= 1'b1;
                        if (cnt == CNT_ONE) begin
                            cnt   <= '0;
                            pulse <= 1'b0;
                            done  <= 1'b1;
                            if (GAP == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= LOCK;
                                lock_cnt <= GAP_L;
                            end
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                LOCK: begin
                    drop <= tick;
                    if (lock_cnt <= LOCK_ONE) begin
                        lock_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - LOCK_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
